// File: rtl/imm_ext_stage.sv
// Immediate / control-transfer target generation between decode and execute.
// Results are queued in a 2-entry skid buffer; every output comes straight from a register.
module imm_ext_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned JIDX_W = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ext_mode,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_target,
    output logic              out_illegal
);

    localparam int unsigned PAD_W  = DATA_W - IMM_W;
    localparam int unsigned JFLD_W = JIDX_W + 2;

    localparam logic [2:0] MODE_ZERO   = 3'd0;
    localparam logic [2:0] MODE_SIGN   = 3'd1;
    localparam logic [2:0] MODE_HIGH   = 3'd2;
    localparam logic [2:0] MODE_BRANCH = 3'd3;
    localparam logic [2:0] MODE_JUMP   = 3'd4;

    // Low bits of the target replaced by {jidx, 2'b00} on a jump.
    localparam logic [DATA_W-1:0] JUMP_MASK = DATA_W'({JFLD_W{1'b1}});

    typedef struct packed {
        logic [DATA_W-1:0] immVal;
        logic [DATA_W-1:0] target;
        logic              illegal;
    } entry_t;

    entry_t      newEntry;
    entry_t      headQ, headD;
    entry_t      tailQ, tailD;
    logic [1:0]  countQ, countD;
    logic        outValidQ, outValidD;
    logic        inReadyQ, inReadyD;
    logic        push, pop;

    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] sextImm;
    logic [DATA_W-1:0] branchImm;
    logic [DATA_W-1:0] jumpImm;

    // Combinational extension and target computation on the request inputs.
    always_comb begin
        pc4       = pc + DATA_W'(4);
        sextImm   = {{PAD_W{imm[IMM_W-1]}}, imm};
        branchImm = sextImm << 2;
        jumpImm   = DATA_W'({jidx, 2'b00});
        newEntry  = '0;
        case (ext_mode)
            MODE_ZERO: begin
                newEntry.immVal = DATA_W'(imm);
                newEntry.target = pc4;
            end
            MODE_SIGN: begin
                newEntry.immVal = sextImm;
                newEntry.target = pc4;
            end
            MODE_HIGH: begin
                newEntry.immVal = {imm, {PAD_W{1'b0}}};
                newEntry.target = pc4;
            end
            MODE_BRANCH: begin
                newEntry.immVal = branchImm;
                newEntry.target = pc4 + branchImm;
            end
            MODE_JUMP: begin
                newEntry.immVal = jumpImm;
                newEntry.target = (pc4 & ~JUMP_MASK) | jumpImm;
            end
            default: begin
                newEntry.illegal = 1'b1;
            end
        endcase
    end

    assign push = in_valid & inReadyQ & ~flush;
    assign pop  = outValidQ & out_ready;

    // Buffer next state; the head register is kept zero whenever the buffer is empty.
    always_comb begin
        countD = countQ;
        headD  = headQ;
        tailD  = tailQ;
        if (flush) begin
            countD = 2'd0;
            headD  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (countQ == 2'd0) begin
                        headD = newEntry;
                    end else begin
                        tailD = newEntry;
                    end
                    countD = countQ + 2'd1;
                end
                2'b01: begin
                    headD  = (countQ == 2'd2) ? tailQ : '0;
                    countD = countQ - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the head is replaced in place.
                    headD = newEntry;
                end
                default: begin
                end
            endcase
        end
        outValidD = (countD != 2'd0);
        inReadyD  = (countD != 2'd2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            countQ    <= 2'd0;
            headQ     <= '0;
            tailQ     <= '0;
            outValidQ <= 1'b0;
            inReadyQ  <= 1'b0;
        end else begin
            countQ    <= countD;
            headQ     <= headD;
            tailQ     <= tailD;
            outValidQ <= outValidD;
            inReadyQ  <= inReadyD;
        end
    end

    assign in_ready    = inReadyQ;
    assign out_valid   = outValidQ;
    assign out_imm     = headQ.immVal;
    assign out_target  = headQ.target;
    assign out_illegal = headQ.illegal;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed bench for imm_ext_stage: a vector table for the extension modes plus
// hand-written backpressure, flush and reset sequences.
module tb_imm_ext_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ext_mode;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic        out_illegal;

    int checks;
    int errors;

    imm_ext_stage dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ext_mode   (ext_mode),
        .imm        (imm),
        .jidx       (jidx),
        .pc         (pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_target (out_target),
        .out_illegal(out_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [2:0]  mode;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] pc;
        logic [31:0] expImm;
        logic [31:0] expTgt;
        logic        expIll;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkOut(input string nm, input logic v, input logic [31:0] eImm,
                          input logic [31:0] eTgt, input logic eIll);
        chk({nm, ".valid"},   32'(out_valid),   32'(v));
        chk({nm, ".imm"},     out_imm,          eImm);
        chk({nm, ".target"},  out_target,       eTgt);
        chk({nm, ".illegal"}, 32'(out_illegal), 32'(eIll));
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] i,
                         input logic [25:0] j, input logic [31:0] p);
        in_valid = v;
        ext_mode = m;
        imm      = i;
        jidx     = j;
        pc       = p;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{"sign",       3'd1, 16'h8001, 26'h0,       32'h0040_0000, 32'hFFFF_8001, 32'h0040_0004, 1'b0};
        vecs[1]  = '{"zero",       3'd0, 16'h8001, 26'h0,       32'h0040_0000, 32'h0000_8001, 32'h0040_0004, 1'b0};
        vecs[2]  = '{"high",       3'd2, 16'h8001, 26'h0,       32'h0040_0000, 32'h8001_0000, 32'h0040_0004, 1'b0};
        vecs[3]  = '{"br_back",    3'd3, 16'hFFFF, 26'h0,       32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[4]  = '{"br_wrap",    3'd3, 16'h0001, 26'h0,       32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0004, 1'b0};
        vecs[5]  = '{"br_neg",     3'd3, 16'h8000, 26'h0,       32'h0000_1000, 32'hFFFE_0000, 32'hFFFE_1004, 1'b0};
        vecs[6]  = '{"jump_max",   3'd4, 16'h1234, 26'h3FFFFFF, 32'hBFC0_0000, 32'h0FFF_FFFC, 32'hBFFF_FFFC, 1'b0};
        vecs[7]  = '{"jump_small", 3'd4, 16'h0000, 26'h0000001, 32'hF000_0010, 32'h0000_0004, 32'hF000_0004, 1'b0};
        vecs[8]  = '{"rsv6",       3'd6, 16'h1234, 26'h5,       32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vecs[9]  = '{"rsv5",       3'd5, 16'hFFFF, 26'h3FFFFFF, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{"rsv7",       3'd7, 16'h8000, 26'h1,       32'h1234_5678, 32'h0,         32'h0,         1'b1};
        vecs[11] = '{"sext_pos",   3'd1, 16'h7FFF, 26'h0,       32'h7FFF_FFFC, 32'h0000_7FFF, 32'h8000_0000, 1'b0};

        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0);
        tick();
        tick();
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        chkOut("reset", 1'b0, 32'h0, 32'h0, 1'b0);

        @(negedge clock);
        reset = 1'b0;
        tick();
        chk("post_reset.in_ready", 32'(in_ready), 32'd1);
        chk("post_reset.valid", 32'(out_valid), 32'd0);

        // Back-to-back stream at full throughput: each vector shows up one cycle after acceptance.
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            drive(1'b1, vecs[k].mode, vecs[k].imm, vecs[k].jidx, vecs[k].pc);
            chk({vecs[k].name, ".in_ready"}, 32'(in_ready), 32'd1);
            tick();
            chkOut(vecs[k].name, 1'b1, vecs[k].expImm, vecs[k].expTgt, vecs[k].expIll);
        end
        @(negedge clock);
        drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0);
        tick();
        chkOut("drain", 1'b0, 32'h0, 32'h0, 1'b0);

        // Backpressure: two entries fill the buffer, the third waits for space.
        @(negedge clock);
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0001, 26'h0, 32'h0000_0100);
        tick();
        @(negedge clock);
        drive(1'b1, 3'd0, 16'h0002, 26'h0, 32'h0000_0200);
        tick();
        chk("bp.full.in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        drive(1'b1, 3'd0, 16'h0003, 26'h0, 32'h0000_0300);
        tick();
        chk("bp.stall.in_ready", 32'(in_ready), 32'd0);
        chkOut("bp.head1", 1'b1, 32'h1, 32'h0000_0104, 1'b0);
        @(negedge clock);
        out_ready = 1'b1;
        chk("bp.pop_cycle.in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp.after_pop.in_ready", 32'(in_ready), 32'd1);
        chkOut("bp.head2", 1'b1, 32'h2, 32'h0000_0204, 1'b0);
        tick();
        chkOut("bp.head3", 1'b1, 32'h3, 32'h0000_0304, 1'b0);
        @(negedge clock);
        drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0);
        tick();
        chkOut("bp.empty", 1'b0, 32'h0, 32'h0, 1'b0);

        // Flush with two entries buffered and a request presented in the flush cycle.
        @(negedge clock);
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h00AA, 26'h0, 32'h0000_1000);
        tick();
        @(negedge clock);
        drive(1'b1, 3'd1, 16'h00BB, 26'h0, 32'h0000_2000);
        tick();
        @(negedge clock);
        flush = 1'b1;
        drive(1'b1, 3'd1, 16'h00CC, 26'h0, 32'h0000_3000);
        tick();
        chk("flush2.in_ready", 32'(in_ready), 32'd1);
        chkOut("flush2", 1'b0, 32'h0, 32'h0, 1'b0);

        // Flush with one entry and in_ready high: the flush-cycle request must be dropped.
        @(negedge clock);
        flush = 1'b0;
        drive(1'b1, 3'd2, 16'h0011, 26'h0, 32'h0000_4000);
        tick();
        @(negedge clock);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'd2, 16'h0022, 26'h0, 32'h0000_5000);
        tick();
        chkOut("flush1", 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0);
        tick();
        chkOut("flush1.no_ghost", 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset with an entry buffered, then normal operation resumes.
        @(negedge clock);
        out_ready = 1'b0;
        drive(1'b1, 3'd3, 16'h0010, 26'h0, 32'h0000_0800);
        tick();
        chkOut("pre_reset", 1'b1, 32'h0000_0040, 32'h0000_0844, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 3'd1, 16'h5555, 26'h0, 32'h0000_9000);
        tick();
        chk("mid_reset.in_ready", 32'(in_ready), 32'd0);
        chkOut("mid_reset", 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0);
        tick();
        chk("rst_release.in_ready", 32'(in_ready), 32'd1);
        chk("rst_release.valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        drive(1'b1, 3'd1, 16'h8001, 26'h0, 32'h0040_0000);
        tick();
        chkOut("after_reset.sign", 1'b1, 32'hFFFF_8001, 32'h0040_0004, 1'b0);
        @(negedge clock);
        drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0);
        tick();
        chkOut("final_drain", 1'b0, 32'h0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
